multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencer for the LEGv8 core datapath: fetch, register-file decode, ALU, data memory and writeback share one set of hardware, and this block drives them one step per state. It classifies the instruction held in the IR, generates every control strobe the decode/execute/memory units consume, and handshakes with instruction and data memory. It also keeps a retired-instruction counter and traps on illegal opcodes or memory timeouts.

## Interface
- MEM_TIMEOUT, default 16: maximum cycles a memory request may wait for its ack before a trap.
- CNT_W, default 32: width of the retired-instruction counter.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  allows a new fetch to start.
- instr  in  32  current IR contents; opcode field is instr[31:21].
- zero  in  1  ALU zero flag, used in EXEC for CBZ.
- imem_ack / dmem_ack  in  1 each  memory acknowledge, sampled on the clock edge while the matching request is high.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  store qualifier on dmem_req.
- ir_write  out  1  load the IR.
- pc_write  out  1  update the PC.
- pc_src  out  1  PC source: 0 = PC+4, 1 = PC+branch offset.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback source: 1 = load data.
- alu_src  out  1  ALU operand B source: 1 = sign-extended immediate.
- reg2loc  out  1  register read port 2 index: 1 = Rt (instr[4:0]).
- alu_op  out  2  00 = add (LD/ST), 01 = pass B (CBZ), 10 = R-type function.
- state  out  3  current state code, for debug.
- trap  out  1  sticky fault flag.
- trap_code  out  2  01 = illegal opcode, 10 = imem timeout, 11 = dmem timeout.
- instret  out  CNT_W  count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE:
  - Go to FETCH when run=1.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_write=1 in the same cycle, go to DECODE.
- DECODE:
  - Latch the opcode class into a class register.
  - LDUR 0x7C2, STUR 0x7C0, ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550 go to EXEC.
  - CBZ (instr[31:24]=0xB4) goes to EXEC.
  - B (instr[31:26]=000101): pc_write=1, pc_src=1, go to FETCH (IDLE if run=0).
  - Any other opcode: go to TRAP with code 01.
- EXEC:
  - R-type: alu_op=10, go to WB.
  - LDUR/STUR: alu_op=00, alu_src=1, go to MEM.
  - CBZ: alu_op=01, reg2loc=1, pc_write=1, pc_src=zero, then go to FETCH/IDLE.
- MEM:
  - dmem_req=1; dmem_we=1 for STUR.
  - STUR also holds reg2loc=1.
  - On dmem_ack, STUR: pc_write=1, pc_src=0, go to FETCH/IDLE.
  - On dmem_ack, LDUR: go to WB.
- WB:
  - reg_write=1; mem_to_reg=1 for LDUR.
  - pc_write=1, pc_src=0, go to FETCH/IDLE.
- Retirement:
  - Each pc_write pulse is one retirement; instret increments by 1.
  - instret wraps from all-ones to 0.
- Control decoding:
  - All strobes are decoded combinationally from state and the class register.
  - Strobes are 0 in every state not listed above.
- run:
  - run is only sampled at instruction boundaries (IDLE and the retiring transition).
  - Deasserting run mid-instruction never aborts it.
- Timeout:
  - A wait counter resets on entry to FETCH or MEM.
  - The counter increments on each cycle with req=1 and ack=0.
  - If it reaches MEM_TIMEOUT, go to TRAP with code 10 or 11, and drop req.
- TRAP:
  - All strobes are 0; trap=1.
  - Only rst_n leaves TRAP.
- Ack outside an active request is ignored.

## Timing
- Reset (rst_n=0 at an edge) takes priority over everything and applies even mid-instruction. After reset:
  - state=IDLE, trap=0, trap_code=00, instret=0.
  - The class register is cleared and all strobes are 0.
- Latency with ack in the first request cycle, first FETCH cycle to retirement edge:
  - B: 2 cycles.
  - CBZ: 3 cycles.
  - R-type and STUR: 4 cycles.
  - LDUR: 5 cycles.
- Each cycle of ack delay adds 1 cycle.
- Request rule: the request stays high continuously until the ack is sampled or the timeout fires. It is never withdrawn early.
- Ack and timeout on the same edge: the ack wins.
- Back-to-back execution with run held high: FETCH of the next instruction starts the cycle after the retirement edge.

## Structure
- definitions.vh holds:
  - Opcode constants (LDUR, STUR, ADD, SUB, AND, ORR, CBZ, B).
  - State codes.
  - alu_op encodings.
  - trap_code values.
- Sub-module op_classify: combinational, instr[31:21] to a 3-bit class (RTYPE, LOAD, STORE, CBZ, B, ILLEGAL). It is shared with a later pipelined decoder.
- The FSM, wait counter and instret counter live in multicycle_ctrl.

## Test plan
- LDUR 0xF84402C9 with 1-cycle acks:
  - States run IDLE, FETCH, DECODE, EXEC, MEM, WB.
  - reg_write=1 and mem_to_reg=1 in WB.
  - instret goes 0 to 1 after 5 cycles.
- ADD 0x8B0902A9 then STUR 0xF80602CB, back-to-back:
  - alu_op=10, then alu_op=00 with alu_src=1, dmem_we=1, reg2loc=1.
  - No reg_write for the STUR; instret=2 after 8 cycles.
- CBZ 0xB4FFFF6B:
  - With zero=1: pc_src=1 on the EXEC pc_write.
  - With zero=0: pc_src=0.
  - B 0x14000040 retires in 2 cycles with pc_src=1.
- Illegal 0xFFFFFFFF:
  - TRAP with trap_code=01 and all strobes 0.
  - run and acks are ignored until rst_n=0.
- dmem_ack withheld on LDUR with MEM_TIMEOUT=16:
  - dmem_req stays high for exactly 16 cycles, then trap_code=11.
  - Repeat with ack on the 16th edge: completes normally, no trap.
- rst_n=0 asserted in MEM, and instret preset near all-ones:
  - The reset returns the block to IDLE with zero strobes on the next edge.
  - instret wraps from all-ones to 0 on retirement.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle sequencer: opcodes, state codes,
// ALU operation selects, trap codes and the instruction class type.
package multicycle_ctrl_pkg;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;     // compared against instr[31:24]
  localparam logic [5:0]  OP_B    = 6'b000101; // compared against instr[31:26]

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_IMEM    = 2'b10;
  localparam logic [1:0] TRAP_DMEM    = 2'b11;

  // CLS_ILLEGAL is the all-zero code so a cleared class register decodes as nothing.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_B       = 3'd5
  } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_op_classify.sv
// Combinational opcode classifier, instr[31:21] to instruction class; also used
// by the pipelined decoder.
module op_classify
  import multicycle_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op_class = CLS_ILLEGAL;
    if (opcode == OP_LDUR)
      op_class = CLS_LOAD;
    else if (opcode == OP_STUR)
      op_class = CLS_STORE;
    else if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      op_class = CLS_RTYPE;
    else if (opcode[10:3] == OP_CBZ)
      op_class = CLS_CBZ;
    else if (opcode[10:5] == OP_B)
      op_class = CLS_B;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// LEGv8 multi-cycle sequencer: FSM, control strobes, memory handshakes with
// timeout, retired-instruction counter and sticky trap.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             reg2loc,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_code,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        trap_code_q, code_d;
  logic              trap_q;
  op_class_t         cls_q, dec_cls;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  instret_q;
  logic              expired, boundary_is_fetch;
  logic              unused_instr_bits;

  op_classify u_classify (
    .opcode   (instr[31:21]),
    .op_class (dec_cls)
  );

  assign unused_instr_bits = ^instr[20:0];
  // Ack is checked before expiry everywhere below, so an ack on the final edge wins.
  assign expired           = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
  assign boundary_is_fetch = run;

  always_comb begin
    state_d = state_q;
    code_d  = TRAP_NONE;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) state_d = ST_DECODE;
        else if (expired) begin
          state_d = ST_TRAP;
          code_d  = TRAP_IMEM;
        end
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_ILLEGAL: begin
            state_d = ST_TRAP;
            code_d  = TRAP_ILLEGAL;
          end
          CLS_B:   state_d = boundary_is_fetch ? ST_FETCH : ST_IDLE;
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_RTYPE:           state_d = ST_WB;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = boundary_is_fetch ? ST_FETCH : ST_IDLE;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack)
          state_d = (cls_q == CLS_STORE) ? (boundary_is_fetch ? ST_FETCH : ST_IDLE) : ST_WB;
        else if (expired) begin
          state_d = ST_TRAP;
          code_d  = TRAP_DMEM;
        end
      end
      ST_WB:   state_d = boundary_is_fetch ? ST_FETCH : ST_IDLE;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg2loc    = 1'b0;
    alu_op     = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
      end
      // B retires straight from DECODE, before the class register is loaded.
      ST_DECODE: begin
        pc_write = (dec_cls == CLS_B);
        pc_src   = (dec_cls == CLS_B);
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_RTYPE: alu_op = ALU_RTYPE;
          CLS_LOAD, CLS_STORE: alu_src = 1'b1;
          CLS_CBZ: begin
            alu_op   = ALU_PASS_B;
            reg2loc  = 1'b1;
            pc_write = 1'b1;
            pc_src   = zero;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        reg2loc  = (cls_q == CLS_STORE);
        pc_write = (cls_q == CLS_STORE) && dmem_ack;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == CLS_LOAD);
        pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cls_q       <= CLS_ILLEGAL;
      wait_q      <= '0;
      trap_q      <= 1'b0;
      trap_code_q <= TRAP_NONE;
      instret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) cls_q <= dec_cls;
      // Counter only runs while a request is held; any state change restarts it.
      if (state_d == state_q && (state_q == ST_FETCH || state_q == ST_MEM))
        wait_q <= wait_q + 1'b1;
      else
        wait_q <= '0;
      if (state_d == ST_TRAP && state_q != ST_TRAP) begin
        trap_q      <= 1'b1;
        trap_code_q <= code_d;
      end
      if (pc_write) instret_q <= instret_q + 1'b1;
    end
  end

  assign state     = state_q;
  assign trap      = trap_q;
  assign trap_code = trap_code_q;
  assign instret   = instret_q;

endmodule
